// File: rtl/stage_instruction_fetch_queued.sv
// Fetch stage: credit-limited imem requester feeding a first-word-fall-through
// instruction queue; execute redirects flush the queue and drop in-flight words.
module stage_instruction_fetch_queued #(
  parameter int              XLEN         = 32,
  parameter int              ILEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              QUEUE_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ex_redirect,
  input  logic [XLEN-1:0]                    ex_pc_target,
  output logic                               imem_req_valid,
  input  logic                               imem_req_ready,
  output logic [XLEN-1:0]                    imem_req_addr,
  input  logic                               imem_rsp_valid,
  input  logic [ILEN-1:0]                    imem_rsp_data,
  output logic                               de_valid,
  input  logic                               de_ready,
  output logic [ILEN-1:0]                    de_instr,
  output logic [XLEN-1:0]                    de_pc,
  output logic [XLEN-1:0]                    de_pc_plus4,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   if_queue_count
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;

  logic [XLEN-1:0] pc_mem  [QUEUE_DEPTH];
  logic [ILEN-1:0] ins_mem [QUEUE_DEPTH];

  logic [CW:0]     used;
  logic            credit;
  logic            fire;
  logic            dropping;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] tgt;

  assign tgt      = ex_pc_target & ~XLEN'(3);
  assign used     = {1'b0, count_q} + {1'b0, outst_q};
  assign credit   = used < (CW+1)'(QUEUE_DEPTH);
  assign dropping = drop_q != '0;

  assign imem_req_valid = !reset && !ex_redirect && credit;
  assign imem_req_addr  = fetch_pc_q;
  assign fire           = imem_req_valid && imem_req_ready;

  // A redirect discards whatever would be pushed or popped this cycle
  assign push = imem_rsp_valid && !dropping && !ex_redirect;
  assign pop  = de_valid && de_ready && !ex_redirect;

  assign de_valid       = !reset && (count_q != '0);
  assign de_instr       = ins_mem[rd_q];
  assign de_pc          = pc_mem[rd_q];
  assign de_pc_plus4    = de_pc + XLEN'(4);
  assign if_queue_count = reset ? '0 : count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    outst_d    = outst_q + CW'(fire) - CW'(imem_rsp_valid);
    if (ex_redirect) begin
      fetch_pc_d = tgt;
      rsp_pc_d   = tgt;
      drop_d     = outst_q - CW'(imem_rsp_valid);
      count_d    = '0;
      wr_d       = '0;
      rd_d       = '0;
    end else begin
      if (fire)
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rsp_valid && dropping)
        drop_d = drop_q - CW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
        wr_d     = wr_q + PW'(1);
      end
      if (pop)
        rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_VECTOR;
      rsp_pc_q   <= RESET_VECTOR;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]  <= rsp_pc_q;
      ins_mem[wr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_stage_instruction_fetch_queued.sv
// Directed bench for the queued fetch stage with an in-order
// variable-latency instruction memory model.
module tb_stage_instruction_fetch_queued;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_pc_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        de_valid;
  logic        de_ready = 1'b1;
  logic [31:0] de_instr;
  logic [31:0] de_pc;
  logic [31:0] de_pc_plus4;
  logic [2:0]  if_queue_count;

  stage_instruction_fetch_queued #(
    .XLEN(32), .ILEN(32), .RESET_VECTOR(32'h0), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ex_redirect(ex_redirect),
    .ex_pc_target(ex_pc_target),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .de_valid(de_valid),
    .de_ready(de_ready),
    .de_instr(de_instr),
    .de_pc(de_pc),
    .de_pc_plus4(de_pc_plus4),
    .if_queue_count(if_queue_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // in-order memory: request in cycle N answers in cycle N+lat
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          lat = 1;
  int          cyc = 0;
  int          nfire = 0;
  logic        s_fire, s_took, s_rst;
  logic [31:0] s_addr;

  always @(posedge clk) begin
    s_fire = imem_req_valid && imem_req_ready;
    s_took = imem_rsp_valid;
    s_addr = imem_req_addr;
    s_rst  = reset;
    cyc++;
    #1;
    if (s_rst) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (s_took) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (s_fire) begin
        mq_addr.push_back(s_addr);
        mq_due.push_back(cyc - 1 + lat);
        nfire++;
      end
    end
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  bit ovf = 1'b0;
  always @(negedge clk)
    if (!reset && (int'(if_queue_count) + mq_addr.size() > QD))
      ovf = 1'b1;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // leaves the bench at the start of cycle 0 after reset release
  task automatic do_reset(input int l, input logic rdy);
    nxt();
    reset = 1'b1;
    ex_redirect = 1'b0;
    de_ready = rdy;
    lat = l;
    nxt();
    nxt();
    reset = 1'b0;
    nfire = 0;
  endtask

  int   found;
  int   nrsp;
  int   n_stale;
  int   got;
  logic [31:0] exp;

  initial begin
    // reset state
    nxt();
    nxt();
    smp();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_de_valid", de_valid, 0);
    check("rst_count", if_queue_count, 0);

    // streaming with 1-cycle memory
    do_reset(1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      smp();
      check($sformatf("t1_addr%0d", k), imem_req_addr, 32'(4 * k));
      check($sformatf("t1_rv%0d", k), imem_req_valid, 1);
      if (k < 2) begin
        check($sformatf("t1_dv%0d", k), de_valid, 0);
      end else begin
        check($sformatf("t1_dv%0d", k), de_valid, 1);
        check($sformatf("t1_pc%0d", k), de_pc, 32'(4 * (k - 2)));
        check($sformatf("t1_p4_%0d", k), de_pc_plus4, 32'(4 * (k - 1)));
        check($sformatf("t1_ins%0d", k), de_instr, inst(32'(4 * (k - 2))));
      end
    end

    // decode stall: exactly QUEUE_DEPTH requests, head held
    do_reset(1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      smp();
      if (k == 5) check("t2_pc_mid", de_pc, 0);
    end
    check("t2_nfire", nfire, QD);
    check("t2_count", if_queue_count, QD);
    check("t2_rv", imem_req_valid, 0);
    check("t2_pc", de_pc, 0);
    check("t2_ins", de_instr, inst(0));
    nxt();
    de_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      smp();
      check($sformatf("t2_dv%0d", j), de_valid, 1);
      check($sformatf("t2_drain%0d", j), de_pc, 32'(4 * j));
    end

    // redirect with three requests in flight
    do_reset(4, 1'b1);
    nxt();
    nxt();
    nxt();
    ex_redirect = 1'b1;
    ex_pc_target = 32'h100;
    smp();
    check("t3_rv_redir", imem_req_valid, 0);
    nxt();
    ex_redirect = 1'b0;
    smp();
    check("t3_addr", imem_req_addr, 32'h100);
    check("t3_rv", imem_req_valid, 1);
    check("t3_count", if_queue_count, 0);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) smp();
      if (de_valid) begin
        found = 1;
        break;
      end
    end
    check("t3_found", found, 1);
    check("t3_pc", de_pc, 32'h100);
    check("t3_ins", de_instr, inst(32'h100));

    // redirect coinciding with a response and a pop
    do_reset(3, 1'b1);
    found = 0;
    n_stale = 0;
    for (int i = 0; i < 30; i++) begin
      smp();
      if (imem_rsp_valid && de_valid && de_ready) begin
        ex_redirect = 1'b1;
        ex_pc_target = 32'h400;
        n_stale = mq_addr.size() - 1;
        found = 1;
        break;
      end
    end
    check("t4_hit", found, 1);
    nxt();
    ex_redirect = 1'b0;
    smp();
    check("t4_count", if_queue_count, 0);
    check("t4_dv", de_valid, 0);
    check("t4_addr", imem_req_addr, 32'h400);
    found = 0;
    nrsp = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) smp();
      if (de_valid) begin
        found = 1;
        break;
      end
      if (imem_rsp_valid) nrsp++;
    end
    check("t4_found", found, 1);
    check("t4_nrsp", nrsp, n_stale + 1);
    check("t4_pc", de_pc, 32'h400);

    // misaligned target, then back-to-back redirects
    do_reset(1, 1'b1);
    nxt();
    nxt();
    nxt();
    nxt();
    ex_redirect = 1'b1;
    ex_pc_target = 32'h103;
    smp();
    check("t5_rv_redir", imem_req_valid, 0);
    nxt();
    ex_redirect = 1'b0;
    smp();
    check("t5_align", imem_req_addr, 32'h100);
    check("t5_rv", imem_req_valid, 1);
    nxt();
    ex_redirect = 1'b1;
    ex_pc_target = 32'h200;
    nxt();
    ex_pc_target = 32'h300;
    nxt();
    ex_redirect = 1'b0;
    smp();
    check("t5_addr", imem_req_addr, 32'h300);
    exp = 32'h300;
    got = 0;
    for (int i = 0; i < 30 && got < 4; i++) begin
      if (i > 0) smp();
      if (de_valid) begin
        check($sformatf("t5_pc%0d", got), de_pc, exp);
        check($sformatf("t5_ins%0d", got), de_instr, inst(exp));
        exp = exp + 32'd4;
        got++;
      end
    end
    check("t5_got", got, 4);

    // reset with queued words and requests in flight
    do_reset(3, 1'b0);
    for (int k = 0; k < 5; k++) nxt();
    smp();
    check("t6_pre_count", if_queue_count, 2);
    check("t6_pre_rv", imem_req_valid, 0);
    nxt();
    reset = 1'b1;
    smp();
    check("t6_dv", de_valid, 0);
    check("t6_count", if_queue_count, 0);
    check("t6_rv", imem_req_valid, 0);
    nxt();
    reset = 1'b0;
    de_ready = 1'b1;
    lat = 1;
    smp();
    check("t6_addr", imem_req_addr, 0);
    check("t6_rv1", imem_req_valid, 1);
    check("t6_rsp", imem_rsp_valid, 0);
    smp();
    check("t6_dv1", de_valid, 0);
    smp();
    check("t6_dv2", de_valid, 1);
    check("t6_pc", de_pc, 0);

    check("no_overflow", ovf, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
